muxn_pipe_reg: RTL and testbench

Parametrised N-input, W-bit selector with a registered output stage and valid/ready handshake on both sides. Generalises the combinational 3-to-1 data selectors in the core to any input count and width. It also adds pipelining, backpressure, flush and out-of-range select detection, so it can sit between pipeline stages, for example writeback-source selection in a pipelined core.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/muxn_andor.sv | 38 +++
 rtl/muxn_pipe_reg.sv | 133 +++++++++++++
 tb/tb_muxn_pipe_reg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the N-input registered selector (muxn_pipe_reg) and
// its combinational AND-OR core (muxn_andor).
//   sel_width(n)  : select width for n inputs, never less than 1 bit.
//   MUX_ERR_DATA  : fill bit for the data word produced by an out-of-range
//                   select (the whole word is replicated from it).
// The beat record {data, sel, err} depends on the user's WIDTH/SEL_W, so it
// is declared as a packed struct inside the user module.
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MUX_ERR_DATA = '0;

    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/muxn_andor.sv
// -----------------------------------------------------------------------------
// muxn_andor
// Purely combinational NUM_IN-to-1 AND-OR selector.
// Ports:
//   i_data [NUM_IN*WIDTH] : packed inputs, input k at [k*WIDTH +: WIDTH]
//   i_sel  [SEL_W]        : binary select
//   o_data [WIDTH]        : selected word, MUX_ERR_DATA fill when out of range
//   o_err                 : i_sel >= NUM_IN
// -----------------------------------------------------------------------------
module muxn_andor
    import mux_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_err
);

    logic [WIDTH-1:0] w_or;

    // Each input is gated by a one-hot decode of the select and ORed in;
    // an out-of-range select matches no term.
    always_comb begin
        w_or = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_or = w_or | (i_data[k*WIDTH +: WIDTH] & {WIDTH{i_sel == SEL_W'(k)}});
        end
    end

    // One extra bit so NUM_IN == 2**SEL_W is representable in the compare.
    assign o_err  = ({1'b0, i_sel} >= (SEL_W+1)'(NUM_IN));
    assign o_data = o_err ? {WIDTH{MUX_ERR_DATA}} : w_or;

endmodule

// File: rtl/muxn_pipe_reg.sv
// -----------------------------------------------------------------------------
// muxn_pipe_reg
// N-input, WIDTH-bit selector with a registered output stage and valid/ready
// handshakes on both sides, plus flush and out-of-range select detection.
//
// Handshake: a beat moves across an interface on a rising edge where its
// valid and ready are both high; valid/data are held by the sender until then.
// Input accept = in_valid_i && in_ready_o (in_ready_o is already low while
// flush_i is high). Output transfer = out_valid_o && out_ready_i.
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync clear of held beats)
//   in_data_i [NUM_IN*WIDTH], in_sel_i [SEL_W], in_valid_i, in_ready_o
//   out_data_o [WIDTH], out_sel_o [SEL_W], out_err_o, out_valid_o, out_ready_i
//
// Build option MUXN_PIPE_SKID_EN: when defined, a second holding entry is
// added and in_ready_o comes straight from a register (no path from
// out_ready_i). When undefined, one output register; in_ready_o combinational.
// -----------------------------------------------------------------------------
module muxn_pipe_reg
    import mux_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]        in_sel_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_sel_o,
    output logic                    out_err_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } beat_t;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    beat_t            w_in_beat;
    logic             w_accept;
    logic             w_xfer;

    beat_t            r_out;
    logic             r_valid;

    muxn_andor #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W)
    ) u_andor (
        .i_data (in_data_i),
        .i_sel  (in_sel_i),
        .o_data (w_sel_data),
        .o_err  (w_sel_err)
    );

    assign w_in_beat = '{data: w_sel_data, sel: in_sel_i, err: w_sel_err};
    assign w_accept  = in_valid_i && in_ready_o;
    assign w_xfer    = r_valid && out_ready_i;

`ifdef MUXN_PIPE_SKID_EN
    beat_t r_skid;
    logic  r_skid_full;

    // Ready depends only on the skid entry being free: the output register
    // may be busy, in which case the incoming beat parks in the skid entry.
    assign in_ready_o = !flush_i && !r_skid_full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_skid      <= '0;
            r_skid_full <= 1'b0;
        end else if (flush_i) begin
            // Data registers keep their contents; only occupancy is cleared.
            r_valid     <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (!r_valid || w_xfer) begin
            // Output register free this cycle: the older skid beat goes first.
            if (r_skid_full) begin
                r_out       <= r_skid;
                r_valid     <= 1'b1;
                r_skid_full <= w_accept;
                if (w_accept) begin
                    r_skid <= w_in_beat;
                end
            end else begin
                r_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_in_beat;
                end
            end
        end else if (w_accept) begin
            r_skid      <= w_in_beat;
            r_skid_full <= 1'b1;
        end
    end
`else
    // Accept whenever the output register is empty or leaving this cycle.
    assign in_ready_o = !flush_i && (!r_valid || out_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (!r_valid || w_xfer) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_out <= w_in_beat;
            end
        end
    end
`endif

    assign out_data_o  = r_out.data;
    assign out_sel_o   = r_out.sel;
    assign out_err_o   = r_out.err;
    assign out_valid_o = r_valid;

endmodule

// File: tb/tb_muxn_pipe_reg.sv
module tb_muxn_pipe_reg;

`ifdef MUXN_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A: NUM_IN=3, WIDTH=32 ----------------
    logic        a_flush, a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
    logic [95:0] a_in_data;
    logic [1:0]  a_in_sel, a_out_sel;
    logic [31:0] a_out_data;

    muxn_pipe_reg #(.NUM_IN(3), .WIDTH(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .in_data_i(a_in_data), .in_sel_i(a_in_sel), .in_valid_i(a_in_valid),
        .in_ready_o(a_in_ready),
        .out_data_o(a_out_data), .out_sel_o(a_out_sel), .out_err_o(a_out_err),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready)
    );

    // ---------------- DUT B: NUM_IN=5, WIDTH=8 ----------------
    logic        b_flush, b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
    logic [39:0] b_in_data;
    logic [2:0]  b_in_sel, b_out_sel;
    logic [7:0]  b_out_data;

    muxn_pipe_reg #(.NUM_IN(5), .WIDTH(8)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .in_data_i(b_in_data), .in_sel_i(b_in_sel), .in_valid_i(b_in_valid),
        .in_ready_o(b_in_ready),
        .out_data_o(b_out_data), .out_sel_o(b_out_sel), .out_err_o(b_out_err),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];     // {data[7:0], sel[2:0], err}
    logic [31:0] a_vals [3];
    int          a_q[$];       // sels accepted by DUT A in the backpressure test

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected DUT A word for a select, from the selection rule.
    function automatic logic [31:0] a_model(input int sel);
        return (sel < 3) ? a_vals[sel] : 32'h0;
    endfunction

    // Expected DUT B beat: pick byte sel of the packed input, zero and err if sel >= 5.
    function automatic logic [11:0] b_model(input logic [39:0] d, input logic [2:0] sel);
        logic [7:0] v;
        logic       e;
        e = (int'(sel) >= 5);
        v = e ? 8'h00 : d[int'(sel)*8 +: 8];
        return {v, sel, e};
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vt [7];

    // ---------------- driver tasks ----------------
    task automatic a_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bi, held, c;
        logic [11:0] head;

        a_vals[0] = 32'h11111111;
        a_vals[1] = 32'h22222222;
        a_vals[2] = 32'h33333333;
        vt[0] = '{2'd0, 32'h11111111, 1'b0};
        vt[1] = '{2'd1, 32'h22222222, 1'b0};
        vt[2] = '{2'd2, 32'h33333333, 1'b0};
        vt[3] = '{2'd3, 32'h00000000, 1'b1};
        vt[4] = '{2'd0, 32'h11111111, 1'b0};
        vt[5] = '{2'd3, 32'h00000000, 1'b1};
        vt[6] = '{2'd2, 32'h33333333, 1'b0};

        a_flush = 0; a_in_valid = 0; a_in_sel = 0; a_out_ready = 1;
        a_in_data = {a_vals[2], a_vals[1], a_vals[0]};
        b_flush = 0; b_in_valid = 0; b_in_sel = 0; b_out_ready = 0; b_in_data = '0;

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_valid", a_out_valid, 0);
        check("rst_data", a_out_data, 0);
        check("rst_sel", a_out_sel, 0);
        check("rst_err", a_out_err, 0);
        check("rst_ready", a_in_ready, 1);

        // ---- table-driven streaming, one beat per cycle ----
        a_step();
        a_in_valid = 1; a_in_sel = vt[0].sel;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stream_ready", a_in_ready, 1);
            a_step();
            check("stream_valid", a_out_valid, 1);
            check("stream_data", a_out_data, vt[i].exp_data);
            check("stream_sel", a_out_sel, vt[i].sel);
            check("stream_err", a_out_err, vt[i].exp_err);
            if (i < 6) a_in_sel = vt[i+1].sel;
            else a_in_valid = 0;
        end
        a_step();
        check("stream_idle", a_out_valid, 0);

        // ---- backpressure: out_ready low for 4 cycles, 3 beats offered ----
        a_out_ready = 0;
        bi = 0;
        for (c = 0; c < 4; c++) begin
            if (c > 0) a_step();
            a_in_valid = (bi < 3); a_in_sel = 2'(bi);
            if (c >= 1) begin
                check("bp_stable_valid", a_out_valid, 1);
                check("bp_stable_data", a_out_data, 32'h11111111);
                check("bp_stable_sel", a_out_sel, 0);
            end
            @(negedge clk);
            if (a_in_valid && a_in_ready) begin
                a_q.push_back(bi);
                bi++;
            end
        end
        check("bp_accepted", bi, CAP);
        a_step();
        a_in_valid = 0; a_out_ready = 1;
        for (c = 0; c < 6 && a_q.size() > 0; c++) begin
            @(negedge clk);
            if (a_out_valid) begin
                check("bp_drain_data", a_out_data, a_model(a_q[0]));
                check("bp_drain_sel", a_out_sel, a_q[0]);
                void'(a_q.pop_front());
            end
            @(posedge clk);
        end
        check("bp_drain_left", a_q.size(), 0);
        #1;
        check("bp_drain_idle", a_out_valid, 0);

        // ---- flush with the holding entries full ----
        a_out_ready = 0; a_in_valid = 1; a_in_sel = 1;
        held = 0;
        for (c = 0; c < 4; c++) begin
            @(negedge clk);
            if (a_in_ready) held++;
            a_step();
        end
        check("fl_filled", held, CAP);
        a_flush = 1;
        @(negedge clk);
        check("fl_ready_low", a_in_ready, 0);
        a_step();
        a_flush = 0; a_in_valid = 0;
        check("fl_valid_cleared", a_out_valid, 0);
        @(negedge clk);
        check("fl_ready_high", a_in_ready, 1);
        a_step();
        check("fl_still_empty", a_out_valid, 0);
        a_out_ready = 1; a_in_valid = 1; a_in_sel = 2;
        a_step();
        a_in_valid = 0;
        check("fl_next_valid", a_out_valid, 1);
        check("fl_next_data", a_out_data, 32'h33333333);
        a_step();
        check("fl_next_alone", a_out_valid, 0);

        // ---- async reset mid-transfer ----
        a_out_ready = 0; a_in_valid = 1; a_in_sel = 1;
        a_step();
        a_in_valid = 0;
        check("mrst_pre_valid", a_out_valid, 1);
        #2 rst = 1;
        #1;
        check("mrst_valid", a_out_valid, 0);
        check("mrst_data", a_out_data, 0);
        check("mrst_sel", a_out_sel, 0);
        check("mrst_ready", a_in_ready, 1);
        a_step();
        rst = 0;
        a_out_ready = 1;
        @(negedge clk);
        check("mrst_after_ready", a_in_ready, 1);
        check("mrst_after_valid", a_out_valid, 0);

        // ---- random traffic on DUT B against a queue model ----
        exp_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            a_step();
            b_in_data   = {$urandom, $urandom_range(0, 255)};
            b_in_sel    = 3'($urandom_range(0, 7));
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            check("rnd_valid", b_out_valid, exp_q.size() > 0);
            if (b_flush)
                check("rnd_ready", b_in_ready, 0);
            else if (CAP == 2)
                check("rnd_ready", b_in_ready, exp_q.size() < 2);
            else
                check("rnd_ready", b_in_ready, (exp_q.size() == 0) || b_out_ready);
            if (b_out_valid && exp_q.size() > 0) begin
                head = exp_q[0];
                check("rnd_beat", {b_out_data, b_out_sel, b_out_err}, head);
            end
            if (b_flush) begin
                exp_q.delete();
            end else begin
                if (b_out_valid && b_out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (b_in_valid && b_in_ready) exp_q.push_back(b_model(b_in_data, b_in_sel));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
